// File: rtl/fan_result_collector.sv
// fan_result_collector
//   Captures one frame of group sums from the FAN reduction network and
//   replays the completed sums one per handshake, in ascending position order.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a frame; in_ready high while rst is low
//   DRAIN | emitting pending sums, lowest pending index first
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  frame handshake
//   in_sums         per-position running sums (N-1 of them)
//   in_sum_valids   which positions hold completed group sums
//   in_vec_ids      per-operand vector IDs (N of them)
//   out_valid/ready result handshake
//   out_sum         selected group sum
//   out_vec_id      vector ID of the last operand of that group
//   out_last        final result of the current frame
//   err_empty       one-cycle pulse after accepting a frame with no sums
//   frames_done     wrapping count of fully drained frames
module fan_result_collector #(
    parameter int N = 32,
    parameter int W = 8,
    parameter int V = 3,
    parameter int S = W + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-2:0][S-1:0]     in_sums,
    input  logic [N-2:0]            in_sum_valids,
    input  logic [N-1:0][V-1:0]     in_vec_ids,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [S-1:0]            out_sum,
    output logic [V-1:0]            out_vec_id,
    output logic                    out_last,
    output logic                    err_empty,
    output logic [15:0]             frames_done
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state;
    logic [N-2:0][S-1:0]    sum_reg;
    logic [N-1:0][V-1:0]    id_reg;
    logic [N-2:0]           pending;
    logic [N-2:0]           sel;
    logic [15:0]            done_count;
    logic                   accept;

    // rst is part of in_ready so nothing is accepted while reset is held.
    assign in_ready    = (state == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == DRAIN);
    assign frames_done = done_count;

    // Lowest set pending bit wins: scan downward so the last hit is the lowest.
    // Everything here depends only on registered state.
    always_comb begin
        sel        = '0;
        out_sum    = '0;
        out_vec_id = '0;
        for (int i = N - 2; i >= 0; i--) begin
            if (pending[i]) begin
                sel        = '0;
                sel[i]     = 1'b1;
                out_sum    = sum_reg[i];
                out_vec_id = id_reg[i+1];
            end
        end
    end

    assign out_last = (state == DRAIN) && ((pending & ~sel) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sum_reg    <= '0;
            id_reg     <= '0;
            pending    <= '0;
            err_empty  <= 1'b0;
            done_count <= 16'd0;
        end else begin
            err_empty <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_reg <= in_sums;
                        id_reg  <= in_vec_ids;
                        pending <= in_sum_valids;
                        if (|in_sum_valids)
                            state <= DRAIN;
                        else
                            err_empty <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        pending <= pending & ~sel;
                        if (out_last) begin
                            state      <= IDLE;
                            done_count <= done_count + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
